// File: rtl/fpu_pkg.sv
// Shared FPU definitions: sequencer states, IEEE-754 single constants and the
// reciprocal seed table used by the Newton-Raphson reciprocal unit.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_MUL_T,
        S_MUL_X,
        S_PACK
    } nr_state_t;

    localparam int          BIAS     = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF  = 8'hFF;
    localparam logic [7:0]  EXP_ZERO = 8'h00;

    // Entry i ~= 256 / (1 + (i + 0.5)/16): 1/m at the centre of each m-bucket, as 0.xxxxxxxx.
    localparam logic [15:0][7:0] SEED_TABLE = {
        8'd130, 8'd134, 8'd139, 8'd144, 8'd149, 8'd155, 8'd161, 8'd167,
        8'd174, 8'd182, 8'd191, 8'd200, 8'd210, 8'd221, 8'd234, 8'd248
    };

endpackage

// File: rtl/fpu_nr_seed_lut.sv
// Combinational seed lookup: top four fraction bits -> 8-bit approximation of 1/m.
module fpu_nr_seed_lut
    import fpu_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] seed
);

    assign seed = SEED_TABLE[idx];

endmodule

// File: rtl/fpu_nr_reciprocal.sv
// Single-precision reciprocal by Newton-Raphson on a shared 32x32 multiplier.
// Fixed latency of 2*NR_ITERS+2 cycles regardless of operand class.
module fpu_nr_reciprocal
    import fpu_pkg::*;
#(
    parameter int NR_ITERS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] recip,
    output logic        dz,
    output logic        nv
);

    nr_state_t   state, state_nxt;
    logic [2:0]  iter_q;
    logic [31:0] div_q, x_q, t_q, recip_q;
    logic        dz_q, nv_q;
    logic [7:0]  seed;
    logic [31:0] m_val, mul_a, mul_b, mul_q;
    logic [63:0] prod;
    logic [31:0] pack_res;
    logic        pack_dz, pack_nv;
    logic [22:0] pack_mant;
    int          pack_exp;

    fpu_nr_seed_lut u_seed (
        .idx  (div_q[22:19]),
        .seed (seed)
    );

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  state_nxt = start ? S_SEED : S_IDLE;
            S_SEED:  begin busy = 1'b1; state_nxt = S_MUL_T; end
            S_MUL_T: begin busy = 1'b1; state_nxt = S_MUL_X; end
            S_MUL_X: begin
                busy      = 1'b1;
                state_nxt = (int'(iter_q) + 1 < NR_ITERS) ? S_MUL_T : S_PACK;
            end
            // PACK is the done cycle and is already idle, so a new start is taken here.
            S_PACK:  begin done = 1'b1; state_nxt = start ? S_SEED : S_IDLE; end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q  <= '0;
            recip_q <= '0;
            dz_q    <= 1'b0;
            nv_q    <= 1'b0;
        end else begin
            case (state)
                S_SEED:  iter_q <= '0;
                S_MUL_X: iter_q <= iter_q + 3'd1;
                S_PACK: begin
                    recip_q <= pack_res;
                    dz_q    <= pack_dz;
                    nv_q    <= pack_nv;
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand and iterate registers carry no reset; they are always rewritten before being consumed.
    always_ff @(posedge clk) begin
        if (start && !busy)     div_q <= divisor;
        if (state == S_SEED)    x_q   <= {1'b0, seed, 23'h0};
        if (state == S_MUL_T)   t_q   <= mul_q;
        if (state == S_MUL_X)   x_q   <= mul_q;
    end

    // m = 1.f in Q1.31; 2 - t wraps naturally in 32 bits since t lies in (0, 2).
    assign m_val = {1'b1, div_q[22:0], 8'h00};

    always_comb begin
        mul_a = m_val;
        mul_b = x_q;
        if (state == S_MUL_X) begin
            mul_a = x_q;
            mul_b = 32'd0 - t_q;
        end
    end

    assign prod  = 64'(mul_a) * 64'(mul_b);
    assign mul_q = 32'(prod >> 31);

    always_comb begin
        pack_res  = '0;
        pack_dz   = 1'b0;
        pack_nv   = 1'b0;
        pack_mant = '0;
        pack_exp  = 0;
        if (div_q[30:23] == EXP_INF) begin
            if (div_q[22:0] != '0) begin
                pack_res = QNAN;
                pack_nv  = 1'b1;
            end else begin
                pack_res = {div_q[31], 31'h0};
            end
        end else if (div_q[30:23] == EXP_ZERO) begin
            pack_res = {div_q[31], EXP_INF, 23'h0};
            pack_dz  = 1'b1;
        end else begin
            if (div_q[22:0] == '0) begin
                pack_exp = 2 * BIAS - int'(div_q[30:23]);
            end else begin
                // x sits in (0.5,1): the bit below its leading one starts the mantissa.
                pack_exp  = 2 * BIAS - 1 - int'(div_q[30:23]);
                pack_mant = 23'(x_q >> 7);
            end
            if (pack_exp <= 0) pack_res = {div_q[31], 31'h0};
            else               pack_res = {div_q[31], 8'(pack_exp), pack_mant};
        end
    end

    assign recip = (state == S_PACK) ? pack_res : recip_q;
    assign dz    = (state == S_PACK) ? pack_dz  : dz_q;
    assign nv    = (state == S_PACK) ? pack_nv  : nv_q;

endmodule
